// File: rtl/counter_reader_pkg.sv
// Shared types and defaults for the 64-bit counter snapshot reader.
// Used by the reader, the counter block and the bench.
package counter_reader_pkg;

   localparam int PKG_DATABUS  = 32;
   localparam int PKG_COUNTLEN = 64;
   localparam int PKG_TIMEOUT  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_LO = 2'd1,
      RD_HI = 2'd2,
      OUT   = 2'd3
   } state_e;

endpackage

// File: rtl/counter_reader.sv
// Reads a 64-bit counter as two atomic 32-bit halves and presents
// the assembled value plus its difference from the previous snapshot.
module counter_reader
   import counter_reader_pkg::*;
#(
   parameter int DATABUS  = PKG_DATABUS,
   parameter int COUNTLEN = PKG_COUNTLEN,
   parameter int TIMEOUT  = PKG_TIMEOUT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sample_i,
   output logic                req_o,
   output logic                atomic_o,
   input  logic                ack_i,
   input  logic [DATABUS-1:0]  data_i,
   output logic [COUNTLEN-1:0] value_o,
   output logic [COUNTLEN-1:0] delta_o,
   output logic                valid_o,
   input  logic                ready_i,
   output logic                busy_o,
   output logic                timeout_o
);

   localparam int WW = $clog2(TIMEOUT + 1);

   state_e              r_state;
   logic                r_req;
   logic [WW-1:0]       r_wait;
   logic [DATABUS-1:0]  r_lo;
   logic [COUNTLEN-1:0] r_value;
   logic [COUNTLEN-1:0] r_delta;
   logic                r_timeout;

   logic                w_ack;
   logic                w_expire;
   logic [COUNTLEN-1:0] w_new;

   // An ack only counts while a request is actually on the bus.
   assign w_ack    = r_req & ack_i;
   assign w_expire = r_req & ~ack_i
                   & (r_wait == WW'(TIMEOUT - 1));
   assign w_new    = {data_i, r_lo};

   assign req_o     = r_req;
   assign atomic_o  = r_req & (r_state == RD_LO);
   assign valid_o   = (r_state == OUT);
   assign busy_o    = (r_state != IDLE);
   assign value_o   = r_value;
   assign delta_o   = r_delta;
   assign timeout_o = r_timeout;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_req     <= 1'b0;
         r_wait    <= '0;
         r_lo      <= '0;
         r_value   <= '0;
         r_delta   <= '0;
         r_timeout <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (sample_i) begin
                  r_state <= RD_LO;
                  r_wait  <= '0;
               end
            end
            RD_LO, RD_HI: begin
               // Each read opens with one request-free cycle,
               // which gives the gap between the two halves.
               if (w_ack) begin
                  r_req  <= 1'b0;
                  r_wait <= '0;
                  if (r_state == RD_LO) begin
                     r_lo    <= data_i;
                     r_state <= RD_HI;
                  end else begin
                     r_value <= w_new;
                     r_delta <= w_new - r_value;
                     r_state <= OUT;
                  end
               end else if (w_expire) begin
                  r_req     <= 1'b0;
                  r_timeout <= 1'b1;
                  r_state   <= IDLE;
               end else begin
                  r_req <= 1'b1;
                  if (r_req) r_wait <= r_wait + WW'(1);
               end
            end
            OUT: begin
               if (ready_i) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
